video_timing_gen: RTL and testbench

Parametrised raster timing generator: the next generation of the fixed 640x480 `video_gen` counter. Produces registered, glitch-free sync, data-enable and pixel coordinates for any timing set, plus frame and line strobes and a frame counter. Sits between the pixel-clock PLL and the pixel pipeline; downstream logic drives colour from `hcount`/`vcount` and uses `sof`/`vblank_start` for frame-buffer handover.

---
 rtl/video_timing_gen.sv | 135 +++++++++++++
 tb/tb_video_timing_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator. Two free-running counters (hc, vc)
// walk the full raster; every ce edge registers the decode of the current
// counter position, so all outputs come directly from flops and are aligned
// with each other, one clk behind the counter state.
//
// Ports:
//   clk          in   pixel clock
//   reset        in   asynchronous active-high reset
//   ce           in   pixel clock enable
//   hcount       out  horizontal position of the output pixel (CNT_W)
//   vcount       out  vertical position of the output line (CNT_W)
//   de           out  active-area data enable
//   hsync        out  horizontal sync, active level HSYNC_POL
//   vsync        out  vertical sync, active level VSYNC_POL
//   sof          out  one-clk strobe at pixel (0,0)
//   sol          out  one-clk strobe at hcount=0 of each active line
//   vblank_start out  one-clk strobe at (0, V_ACTIVE)
//   frame_cnt    out  completed-frame count, wraps (FRAME_W)
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int CNT_W     = 11,
  parameter int FRAME_W   = 8,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 64,
  parameter int H_BP      = 114,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 16,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               sof,
  output logic               sol,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All comparison constants are pre-cast to the counter width. Sync end
  // positions are strictly below the totals, so they always fit.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hc_reg;
  logic [CNT_W-1:0] vc_reg;
  logic [CNT_W-1:0] hc_next;
  logic [CNT_W-1:0] vc_next;
  logic             h_wrap;
  logic             frame_end;
  logic             de_next;
  logic             hsync_next;
  logic             vsync_next;
  logic             sof_next;
  logic             sol_next;
  logic             vblank_start_next;

  // Counter advance and output decode of the current (hc, vc).
  always_comb begin
    h_wrap    = (hc_reg == H_LAST);
    frame_end = h_wrap && (vc_reg == V_LAST);

    hc_next = h_wrap ? '0 : hc_reg + CNT_W'(1);
    vc_next = vc_reg;
    if (h_wrap) begin
      vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + CNT_W'(1);
    end

    de_next    = (hc_reg < H_ACT_C) && (vc_reg < V_ACT_C);
    hsync_next = ((hc_reg >= HS_START) && (hc_reg < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    // vsync depends on vc only, so its edges fall on hc=0 automatically.
    vsync_next = ((vc_reg >= VS_START) && (vc_reg < VS_END)) ? VSYNC_POL : ~VSYNC_POL;

    sof_next          = (hc_reg == '0) && (vc_reg == '0);
    sol_next          = (hc_reg == '0) && (vc_reg < V_ACT_C);
    vblank_start_next = (hc_reg == '0) && (vc_reg == V_ACT_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_reg       <= '0;
      vc_reg       <= '0;
      hcount       <= '0;
      vcount       <= '0;
      de           <= 1'b0;
      hsync        <= ~HSYNC_POL;
      vsync        <= ~VSYNC_POL;
      sof          <= 1'b0;
      sol          <= 1'b0;
      vblank_start <= 1'b0;
      frame_cnt    <= '0;
    end else if (ce) begin
      hc_reg       <= hc_next;
      vc_reg       <= vc_next;
      hcount       <= hc_reg;
      vcount       <= vc_reg;
      de           <= de_next;
      hsync        <= hsync_next;
      vsync        <= vsync_next;
      sof          <= sof_next;
      sol          <= sol_next;
      vblank_start <= vblank_start_next;
      if (frame_end) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end else begin
      // Strobes drop on any non-ce edge so they stay exactly one clk wide
      // however ce is patterned; everything else holds.
      sof          <= 1'b0;
      sol          <= 1'b0;
      vblank_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Two instances: one with the default 834x500 timing (first lines only) and
// one with the 14x7 small set, HSYNC_POL=VSYNC_POL=1, FRAME_W=2. The small
// instance is checked against a hand table, then against a pixel-index model
// with ce=1, with random ce, and across an asynchronous mid-line reset.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        de;
    logic        hs;
    logic        vs;
    logic        sof;
    logic        sol;
    logic        vb;
    logic [1:0]  fc;
  } obs_t;

  typedef struct packed {
    logic ce;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default-timing instance
  logic        rst_def;
  logic        ce_def;
  logic [10:0] hcount_def;
  logic [10:0] vcount_def;
  logic        de_def, hsync_def, vsync_def, sof_def, sol_def, vb_def;
  logic [7:0]  fc_def;

  video_timing_gen u_def (
    .clk          (clk),
    .reset        (rst_def),
    .ce           (ce_def),
    .hcount       (hcount_def),
    .vcount       (vcount_def),
    .de           (de_def),
    .hsync        (hsync_def),
    .vsync        (vsync_def),
    .sof          (sof_def),
    .sol          (sol_def),
    .vblank_start (vb_def),
    .frame_cnt    (fc_def)
  );

  // Small-set instance
  logic        rst_sm;
  logic        ce_sm;
  logic [10:0] hcount_sm;
  logic [10:0] vcount_sm;
  logic        de_sm, hsync_sm, vsync_sm, sof_sm, sol_sm, vb_sm;
  logic [1:0]  fc_sm;

  video_timing_gen #(
    .FRAME_W  (2),
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_sm (
    .clk          (clk),
    .reset        (rst_sm),
    .ce           (ce_sm),
    .hcount       (hcount_sm),
    .vcount       (vcount_sm),
    .de           (de_sm),
    .hsync        (hsync_sm),
    .vsync        (vsync_sm),
    .sof          (sof_sm),
    .sol          (sol_sm),
    .vblank_start (vb_sm),
    .frame_cnt    (fc_sm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sm_obs();
    obs_t o;
    o.hc  = hcount_sm;
    o.vc  = vcount_sm;
    o.de  = de_sm;
    o.hs  = hsync_sm;
    o.vs  = vsync_sm;
    o.sof = sof_sm;
    o.sol = sol_sm;
    o.vb  = vb_sm;
    o.fc  = fc_sm;
    return o;
  endfunction

  // Expected small-set outputs after k ce edges since reset. The output
  // after edge k shows raster pixel index k-1 within a 98-pixel frame.
  function automatic obs_t model(int k);
    obs_t o;
    int p, h, v;
    o = '0;
    if (k == 0) return o;
    p = (k - 1) % 98;
    h = p % 14;
    v = p / 14;
    o.hc  = 11'(h);
    o.vc  = 11'(v);
    o.de  = (h < 8) && (v < 4);
    o.hs  = (h >= 10) && (h < 12);
    o.vs  = (v == 5);
    o.sof = (p == 0);
    o.sol = (h == 0) && (v < 4);
    o.vb  = (h == 0) && (v == 4);
    o.fc  = 2'(k / 98);
    return o;
  endfunction

  function automatic vec_t mk(logic ce, int hc, int vc, logic de, logic hs, logic vs,
                              logic sof, logic sol, logic vb, int fc);
    vec_t r;
    r.ce      = ce;
    r.exp.hc  = 11'(hc);
    r.exp.vc  = 11'(vc);
    r.exp.de  = de;
    r.exp.hs  = hs;
    r.exp.vs  = vs;
    r.exp.sof = sof;
    r.exp.sol = sol;
    r.exp.vb  = vb;
    r.exp.fc  = 2'(fc);
    return r;
  endfunction

  task automatic chk_obs(string name, int idx, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got hc=%0d vc=%0d de=%b hs=%b vs=%b sof=%b sol=%b vb=%b fc=%0d want hc=%0d vc=%0d de=%b hs=%b vs=%b sof=%b sol=%b vb=%b fc=%0d",
               name, idx, act.hc, act.vc, act.de, act.hs, act.vs, act.sof, act.sol, act.vb, act.fc,
               exp.hc, exp.vc, exp.de, exp.hs, exp.vs, exp.sof, exp.sol, exp.vb, exp.fc);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic reset_sm();
    rst_sm = 1'b1;
    ce_sm  = 1'b0;
    step();
    step();
    rst_sm = 1'b0;
  endtask

  vec_t vecs[18];

  initial begin
    int de_cnt[2];
    int hs_cnt[2];
    int hs_first[2];
    int hs_last[2];
    int vs_cnt, sof_cnt, sol_cnt, vb_cnt;
    int k, found;
    int fc_seq[$];
    logic [1:0] fc_prev;
    logic last_sof, last_sol, last_vb;
    obs_t exp, prev;

    // Hand-computed small-set vectors starting from reset.
    vecs[0]  = mk(1,  0, 0, 1, 0, 0, 1, 1, 0, 0);
    vecs[1]  = mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1,  1, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1,  2, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0,  2, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1,  3, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1,  4, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1,  5, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1,  6, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1,  7, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1,  8, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(1,  9, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 10, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 11, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 11, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[15] = mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(1,  0, 1, 1, 0, 0, 0, 1, 0, 0);

    rst_def = 1'b1;
    ce_def  = 1'b1;
    rst_sm  = 1'b1;
    ce_sm   = 1'b0;
    repeat (3) step();

    // Reset state of both instances.
    chk_obs("reset_sm", 0, sm_obs(), model(0));
    chk_int("reset_def", {hcount_def, vcount_def, de_def, hsync_def, vsync_def,
                          sof_def, sol_def, vb_def, fc_def},
                         {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});

    // Default timing: first two lines.
    rst_def = 1'b0;
    vs_cnt  = 0;
    for (int l = 0; l < 2; l++) begin
      de_cnt[l] = 0; hs_cnt[l] = 0; hs_first[l] = -1; hs_last[l] = -1;
    end
    for (int j = 1; j <= 2 * 834; j++) begin
      int l;
      step();
      l = (j - 1) / 834;
      if (j == 1) chk_int("def_first_sof", int'(sof_def), 1);
      if (de_def) de_cnt[l]++;
      if (!hsync_def) begin
        hs_cnt[l]++;
        if (hs_first[l] < 0) hs_first[l] = int'(hcount_def);
        hs_last[l] = int'(hcount_def);
      end
      if (!vsync_def) vs_cnt++;
      if (j == 835) chk_int("def_line1_vcount", int'(vcount_def), 1);
    end
    for (int l = 0; l < 2; l++) begin
      chk_int($sformatf("def_de_cnt_l%0d", l), de_cnt[l], 640);
      chk_int($sformatf("def_hs_cnt_l%0d", l), hs_cnt[l], 64);
      chk_int($sformatf("def_hs_first_l%0d", l), hs_first[l], 656);
      chk_int($sformatf("def_hs_last_l%0d", l), hs_last[l], 719);
    end
    chk_int("def_vsync_idle", vs_cnt, 0);

    // Table-driven small-set vectors.
    rst_sm = 1'b0;
    for (int i = 0; i < 18; i++) begin
      ce_sm = vecs[i].ce;
      step();
      chk_obs("table", i, sm_obs(), vecs[i].exp);
    end

    // ce=1 for five frames against the model; also strobe counts and frame_cnt.
    reset_sm();
    sof_cnt = 0; sol_cnt = 0; vb_cnt = 0;
    fc_prev = 2'd0;
    ce_sm   = 1'b1;
    for (int kk = 1; kk <= 490; kk++) begin
      step();
      chk_obs("ce1_run", kk, sm_obs(), model(kk));
      if (sof_sm) sof_cnt++;
      if (sol_sm) sol_cnt++;
      if (vb_sm)  vb_cnt++;
      if (fc_sm != fc_prev) begin
        fc_seq.push_back(int'(fc_sm));
        chk_int("fc_inc_at_h13", int'(hcount_sm), 13);
        chk_int("fc_inc_at_v6", int'(vcount_sm), 6);
        fc_prev = fc_sm;
      end
    end
    chk_int("ce1_sof_cnt", sof_cnt, 5);
    chk_int("ce1_sol_cnt", sol_cnt, 20);
    chk_int("ce1_vb_cnt", vb_cnt, 5);
    chk_int("fc_seq_len", fc_seq.size(), 5);
    if (fc_seq.size() == 5) begin
      chk_int("fc_seq0", fc_seq[0], 1);
      chk_int("fc_seq1", fc_seq[1], 2);
      chk_int("fc_seq2", fc_seq[2], 3);
      chk_int("fc_seq3", fc_seq[3], 0);
      chk_int("fc_seq4", fc_seq[4], 1);
    end

    // Random ce at 50% for three frames.
    reset_sm();
    k = 0;
    prev = model(0);
    last_sof = 1'b0; last_sol = 1'b0; last_vb = 1'b0;
    for (int cyc = 0; cyc < 3000 && k < 294; cyc++) begin
      ce_sm = 1'($urandom_range(0, 1));
      step();
      if (ce_sm) begin
        k++;
        exp = model(k);
      end else begin
        exp = prev;
        exp.sof = 1'b0;
        exp.sol = 1'b0;
        exp.vb  = 1'b0;
      end
      chk_obs("rand_ce", cyc, sm_obs(), exp);
      if ((sof_sm && last_sof) || (sol_sm && last_sol) || (vb_sm && last_vb)) begin
        chk_int("strobe_width", 2, 1);
      end
      last_sof = sof_sm; last_sol = sol_sm; last_vb = vb_sm;
      prev = exp;
    end
    chk_int("rand_ce_budget", k, 294);

    // Asynchronous reset in the middle of hsync at (10,3).
    reset_sm();
    ce_sm = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (hcount_sm == 11'd10 && vcount_sm == 11'd3) found = 1;
    end
    chk_int("mid_reach", found, 1);
    chk_int("mid_hsync_active", int'(hsync_sm), 1);
    #2;
    rst_sm = 1'b1;
    #1;
    chk_obs("async_reset", 0, sm_obs(), model(0));
    step();
    chk_obs("reset_held", 0, sm_obs(), model(0));
    rst_sm = 1'b0;
    ce_sm  = 1'b1;
    step();
    chk_obs("post_reset", 1, sm_obs(), model(1));
    step();
    chk_obs("post_reset", 2, sm_obs(), model(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
